// File: rtl/c1541_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : c1541_sd_arbiter
// Description : Round-robin arbiter sharing one host sector channel
//               (LBA request/ack and byte buffer port) among c1541 drives.
// Revision    : 1.0  initial release
// ============================================================================
module c1541_sd_arbiter #(
    parameter int          NDRIVES = 4,
    parameter logic [23:0] TIMEOUT = 24'd16000000
) (
    input  logic                   clk32,
    input  logic                   reset_n,
    input  logic [NDRIVES-1:0]     drv_rd,
    input  logic [NDRIVES-1:0]     drv_wr,
    input  logic [32*NDRIVES-1:0]  drv_lba,
    input  logic [8*NDRIVES-1:0]   drv_buff_din,
    output logic [NDRIVES-1:0]     drv_ack,
    output logic [NDRIVES-1:0]     drv_err,
    output logic [NDRIVES-1:0]     drv_buff_wr,
    output logic [31:0]            host_lba,
    output logic                   host_rd,
    output logic                   host_wr,
    input  logic                   host_ack,
    input  logic                   host_buff_wr,
    output logic [7:0]             host_buff_din,
    output logic                   busy,
    output logic [1:0]             grant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [23:0] c_tmo_last = TIMEOUT - 24'd1;

    logic [1:0]         r_state;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_grant;
    logic [31:0]        r_lba;
    logic               r_host_rd;
    logic               r_host_wr;
    logic [NDRIVES-1:0] r_drv_err;
    logic [23:0]        r_timer;

    logic               w_any;
    logic [1:0]         w_sel;
    int                 w_idx;
    logic [31:0]        w_sel_lba;
    logic               w_sel_wr;
    logic               w_gnt_req;
    logic [NDRIVES-1:0] w_gnt_onehot;
    logic [1:0]         w_next_ptr;

    // Walk from the farthest offset back to rr_ptr so the nearest requester wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_rr_ptr;
        w_idx = 0;
        for (int k = NDRIVES - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NDRIVES) w_idx = w_idx - NDRIVES;
            for (int i = 0; i < NDRIVES; i++) begin
                if (i == w_idx && (drv_rd[i] || drv_wr[i])) begin
                    w_any = 1'b1;
                    w_sel = 2'(i);
                end
            end
        end
    end

    always_comb begin
        drv_ack       = '0;
        drv_buff_wr   = '0;
        host_buff_din = 8'h00;
        w_gnt_req     = 1'b0;
        w_gnt_onehot  = '0;
        w_sel_lba     = 32'h0;
        w_sel_wr      = 1'b0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (r_grant == 2'(i)) begin
                w_gnt_onehot[i] = 1'b1;
                w_gnt_req       = drv_rd[i] | drv_wr[i];
                if (r_state == S_XFER) begin
                    drv_ack[i]     = host_ack;
                    drv_buff_wr[i] = host_buff_wr;
                end
                if (r_state != S_IDLE) host_buff_din = drv_buff_din[8*i +: 8];
            end
            if (w_sel == 2'(i)) begin
                w_sel_lba = drv_lba[32*i +: 32];
                w_sel_wr  = drv_wr[i];
            end
        end
    end

    assign w_next_ptr = (r_grant == 2'(NDRIVES - 1)) ? 2'd0 : r_grant + 2'd1;

    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= 2'd0;
            r_grant   <= 2'd0;
            r_lba     <= 32'h0;
            r_host_rd <= 1'b0;
            r_host_wr <= 1'b0;
            r_drv_err <= '0;
            r_timer   <= 24'd0;
        end else begin
            r_drv_err <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel;
                        r_lba     <= w_sel_lba;
                        r_host_rd <= !w_sel_wr;
                        r_host_wr <= w_sel_wr;
                        r_timer   <= 24'd0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (host_ack) begin
                        r_state <= S_XFER;
                    end else if (!w_gnt_req) begin
                        r_host_rd <= 1'b0;
                        r_host_wr <= 1'b0;
                        r_state   <= S_GAP;
                    end else if (r_timer == c_tmo_last) begin
                        r_host_rd <= 1'b0;
                        r_host_wr <= 1'b0;
                        r_drv_err <= w_gnt_onehot;
                        r_state   <= S_GAP;
                    end else if (r_timer != 24'hFFFFFF) begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_XFER: begin
                    // A drive dropping its request here is ignored; only ack ends the transfer.
                    if (!host_ack) begin
                        r_host_rd <= 1'b0;
                        r_host_wr <= 1'b0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign drv_err  = r_drv_err;
    assign host_lba = r_lba;
    assign host_rd  = r_host_rd;
    assign host_wr  = r_host_wr;
    assign busy     = (r_state != S_IDLE);
    assign grant    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_c1541_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_c1541_sd_arbiter
// Description : Scoreboard bench for c1541_sd_arbiter host-request arbitration.
// Revision    : 1.0  initial release
// ============================================================================
module tb_c1541_sd_arbiter;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] lba;
        logic        wr;
    } req_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   drv_rd, drv_wr;
    logic [127:0] drv_lba;
    logic [31:0]  drv_buff_din;
    logic [3:0]   drv_ack, drv_err, drv_buff_wr;
    logic [31:0]  host_lba;
    logic         host_rd, host_wr, host_ack, host_buff_wr;
    logic [7:0]   host_buff_din;
    logic         busy;
    logic [1:0]   grant;

    int   total = 0;
    int   bad   = 0;
    req_t exp_q[$];
    logic [3:0] err_q[$];
    req_t e;
    logic [3:0] e_err;
    logic prev_req = 1'b0;

    c1541_sd_arbiter #(.NDRIVES(4), .TIMEOUT(24'd100)) dut (
        .clk32(clk), .reset_n(reset_n),
        .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_lba(drv_lba), .drv_buff_din(drv_buff_din),
        .drv_ack(drv_ack), .drv_err(drv_err), .drv_buff_wr(drv_buff_wr),
        .host_lba(host_lba), .host_rd(host_rd), .host_wr(host_wr),
        .host_ack(host_ack), .host_buff_wr(host_buff_wr), .host_buff_din(host_buff_din),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every new host request and every error pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if ((host_rd | host_wr) && !prev_req) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_req: got grant=%0d lba=%0h expected none", grant, host_lba);
            end else begin
                e = exp_q.pop_front();
                chk("req_grant", 32'(grant), 32'(e.g));
                chk("req_lba", host_lba, e.lba);
                chk("req_wr", 32'(host_wr), 32'(e.wr));
                chk("req_rd", 32'(host_rd), 32'(!e.wr));
            end
        end
        prev_req = host_rd | host_wr;
        if (drv_err != 4'b0) begin
            if (err_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_err: got %b expected 0000", drv_err);
            end else begin
                e_err = err_q.pop_front();
                chk("err_vec", 32'(drv_err), 32'(e_err));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [1:0] g, input logic [31:0] lba, input logic wr);
        req_t r;
        r.g = g; r.lba = lba; r.wr = wr;
        exp_q.push_back(r);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        @(negedge clk);
        while (!(host_rd | host_wr) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(host_rd | host_wr), 32'd1);
        tick;
    endtask

    // Enter XFER from REQ, run nstb buffer strobes, then end the transfer and pass through GAP.
    task automatic xfer(input int d, input int nstb, input logic [7:0] din);
        int cnt = 0;
        host_ack = 1'b1;
        tick;
        for (int i = 0; i < nstb; i++) begin
            host_buff_wr = 1'b1;
            @(negedge clk);
            if (drv_buff_wr == 4'(1 << d)) cnt++;
            if (i == 0) begin
                chk("xfer_ack", 32'(drv_ack), 32'(1 << d));
                chk("xfer_din", 32'(host_buff_din), 32'(din));
                chk("xfer_busy", 32'(busy), 32'd1);
            end
            tick;
        end
        host_buff_wr = 1'b0;
        chk("xfer_strobes", cnt, nstb);
        host_ack  = 1'b0;
        drv_rd[d] = 1'b0;
        drv_wr[d] = 1'b0;
        tick;
        @(negedge clk);
        chk("gap_req", 32'(host_rd | host_wr), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; drv_rd = '0; drv_wr = '0; drv_lba = '0;
        drv_buff_din = {8'h33, 8'hA5, 8'h5A, 8'h11};
        host_ack = 1'b0; host_buff_wr = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_lba", host_lba, 0);
        chk("rst_rdwr", 32'({host_rd, host_wr}), 0);
        chk("rst_ack", 32'({drv_ack, drv_err, drv_buff_wr}), 0);
        tick;
        reset_n = 1'b1;
        tick;

        // Single read on drive 1 with a full 256-byte sector
        drv_lba[63:32] = 32'h0000_0123;
        push_req(2'd1, 32'h0000_0123, 1'b0);
        drv_rd[1] = 1'b1;
        @(negedge clk);
        chk("rd_before_edge", 32'(host_rd), 0);
        tick;
        @(negedge clk);
        chk("rd_latency", 32'(host_rd), 1);
        repeat (9) tick;
        xfer(1, 256, 8'h5A);
        @(negedge clk);
        chk("rd_idle_after", 32'(busy), 0);
        tick;

        // Round-robin from a fresh reset
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        drv_lba = {32'h0000_1003, 32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
        for (int k = 0; k < 5; k++) begin
            push_req(2'(k % 4), 32'h0000_1000 + 32'(k % 4), 1'b0);
            if (k == 0) drv_rd = 4'hF;
            wait_req("rr_req");
            xfer(k % 4, 2, drv_buff_din[8*(k%4) +: 8]);
            drv_rd = (k < 4) ? 4'hF : 4'h0;
        end

        // Write path, write wins over simultaneous read; rr_ptr now 1
        drv_lba[95:64] = 32'h0000_BEEF;
        push_req(2'd2, 32'h0000_BEEF, 1'b1);
        drv_rd[2] = 1'b1;
        drv_wr[2] = 1'b1;
        wait_req("wr_req");
        xfer(2, 3, 8'hA5);

        // Timeout on drive 0 (rr_ptr 3 -> drive 0), drive 1 then served next
        drv_lba[31:0] = 32'h0000_0A00;
        push_req(2'd0, 32'h0000_0A00, 1'b0);
        err_q.push_back(4'b0001);
        drv_rd[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!host_rd && n < 20) begin @(negedge clk); n++; end
        chk("tmo_req", 32'(host_rd), 1);
        drv_rd[1] = 1'b1;
        push_req(2'd1, 32'h0000_1001, 1'b0);
        n = 0;
        while (drv_err == 4'b0 && n < 300) begin @(negedge clk); n++; end
        chk("tmo_latency", n, 100);
        chk("tmo_rd_low", 32'(host_rd), 0);
        drv_rd[0] = 1'b0;
        wait_req("tmo_next_req");
        xfer(1, 1, 8'h5A);

        // Abort in REQ on drive 3 (rr_ptr 2 -> drive 3)
        drv_lba[127:96] = 32'h3333_0003;
        push_req(2'd3, 32'h3333_0003, 1'b0);
        drv_rd[3] = 1'b1;
        wait_req("abort_req");
        drv_rd[3] = 1'b0;
        @(negedge clk);
        chk("abort_hold", 32'(host_rd), 1);
        tick;
        @(negedge clk);
        chk("abort_rd_low", 32'(host_rd), 0);
        chk("abort_no_err", 32'(drv_err), 0);
        tick;

        // Reset during XFER on drive 2 (rr_ptr 0 -> drive 2)
        drv_lba[95:64] = 32'h2222_0002;
        push_req(2'd2, 32'h2222_0002, 1'b0);
        drv_rd[2] = 1'b1;
        wait_req("rst_xfer_req");
        host_ack = 1'b1;
        tick;
        @(negedge clk);
        chk("rst_xfer_ack", 32'(drv_ack), 32'b0100);
        reset_n = 1'b0;
        drv_rd[0] = 1'b1;
        drv_rd[3] = 1'b1;
        drv_lba[31:0] = 32'h0000_0777;
        push_req(2'd0, 32'h0000_0777, 1'b0);
        tick;
        @(negedge clk);
        chk("rst_mid_rdwr", 32'({host_rd, host_wr}), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_grant", 32'(grant), 0);
        chk("rst_mid_ack", 32'({drv_ack, drv_buff_wr, drv_err}), 0);
        chk("rst_mid_din", 32'(host_buff_din), 0);
        reset_n = 1'b1;
        host_ack = 1'b0;
        wait_req("post_rst_req");
        drv_rd[3:2] = 2'b00;
        xfer(0, 1, 8'h11);

        // Stray ack and buffer strobes while idle
        host_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_buff_wr = 1'b1;
            @(negedge clk);
            chk("stray_ack", 32'(drv_ack), 0);
            chk("stray_bwr", 32'(drv_buff_wr), 0);
            chk("stray_busy", 32'(busy), 0);
            tick;
        end
        host_ack = 1'b0;
        host_buff_wr = 1'b0;
        repeat (3) tick;

        chk("req_queue_empty", exp_q.size(), 0);
        chk("err_queue_empty", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c1541_sd_arbiter.md
Name: c1541_sd_arbiter

Overview:
- Shares the single MiSTer host sector channel (LBA request, ack, 256-byte buffer port) among up to four c1541 drive instances.
- Grants one drive at a time using round-robin priority.
- Latches that drive's LBA and direction, forwards the request to the host and routes buffer traffic to and from the granted drive only.
- Sits between the per-drive track/sector loaders and the top-level sd_* host interface.

Parameters:
- NDRIVES, 4, number of drive ports, legal 1..4.
- TIMEOUT, 24'd16000000, clk32 cycles to wait for host ack before aborting (0.5 s).

Ports:
- clk32 input 1: system clock, 32 MHz.
- reset_n input 1: synchronous, active-low reset.
- drv_rd input NDRIVES: per-drive read request, level, held until that drive's drv_ack falls.
- drv_wr input NDRIVES: per-drive write request, same rules as drv_rd.
- drv_lba input 32*NDRIVES: per-drive LBA; drive i uses bits [32*i+31:32*i].
- drv_buff_din input 8*NDRIVES: per-drive write data toward host.
- drv_ack output NDRIVES: per-drive ack, a copy of host_ack gated to the granted drive.
- drv_err output NDRIVES: one-cycle timeout pulse to the granted drive.
- drv_buff_wr output NDRIVES: per-drive buffer write strobe, gated host_buff_wr.
- host_lba output 32: LBA latched at grant.
- host_rd output 1: read request to host.
- host_wr output 1: write request to host.
- host_ack input 1: host transfer-active level.
- host_buff_wr input 1: host writes host_buff_dout into the drive buffer.
- host_buff_din output 8: granted drive's drv_buff_din; 8'h00 when nothing is granted.
- busy output 1: high in every state except IDLE.
- grant output 2: index of the granted or last-granted drive.

Behaviour:
- Reset (reset_n low at a clk32 edge): state=IDLE, rr_ptr=0, grant=0, host_lba=0, host_rd=host_wr=0, drv_ack=drv_err=drv_buff_wr=0, busy=0, timer=0.
- Reset mid-transfer aborts immediately. No host_rd/host_wr is left asserted.
- The state machine has four states: IDLE, REQ, XFER, GAP.
- IDLE:
  - req[i] = drv_rd[i] | drv_wr[i].
  - If any req is set, select the first set index searching rr_ptr, rr_ptr+1, ... modulo NDRIVES.
  - Latch grant, host_lba, and dir=wr (write wins if drv_rd and drv_wr are both high).
  - Clear timer and go to REQ.
  - host_rd/host_wr assert on the first REQ cycle: 1 clk from the request being seen to host_rd/host_wr high.
- REQ:
  - host_rd = !dir, host_wr = dir.
  - On host_ack=1, go to XFER.
  - If the granted drive drops both drv_rd and drv_wr first, deassert the host request and go to GAP (abort, no err).
  - If timer reaches TIMEOUT-1, pulse drv_err[grant] for 1 cycle and go to GAP.
  - Otherwise timer increments.
- XFER:
  - host_rd/host_wr stay asserted until host_ack falls.
  - drv_ack[grant] = host_ack, combinational. All other drv_ack are 0.
  - drv_buff_wr[grant] = host_buff_wr. All others are 0.
  - host_buff_din = drv_buff_din[grant].
  - When host_ack falls, deassert host_rd/host_wr and go to GAP.
  - Request drop during XFER is ignored; the transfer completes.
- GAP:
  - Lasts 1 cycle and guarantees at least 1 idle cycle between host requests.
  - Sets rr_ptr = (grant+1) mod NDRIVES, then goes to IDLE.
- host_lba, grant and dir are stable from REQ entry until IDLE re-entry. drv_lba changes after grant have no effect.
- host_ack outside XFER: drv_ack all 0, drv_buff_wr all 0. host_ack high in IDLE does not start a grant.
- Requests from drive indices >= NDRIVES do not exist. grant never exceeds NDRIVES-1.
- The timer is 24 bits and saturates; it never wraps.
- Fairness: a continuously requesting drive is granted at most once per NDRIVES grants while others request.

Test Plan:
- Single read: drv_rd[1]=1 with lba 0x00000123 -> host_rd=1 next clk, host_lba=0x123. Host raises ack 10 clk later and drives 256 host_buff_wr strobes -> drv_buff_wr[1] sees all 256, drv_ack=4'b0010 during ack. Ack falls -> host_rd=0, busy=0 two clocks later.
- Round-robin: drv_rd=4'b1111 held and re-raised after each ack -> grant sequence 0,1,2,3,0. host_lba matches each drive's LBA.
- Write path: drv_wr[2]=1, drv_buff_din[2]=0xA5 -> host_wr=1, host_rd=0, host_buff_din=0xA5 during XFER. drv_rd[2] and drv_wr[2] both high -> host_wr chosen.
- Timeout: TIMEOUT=100, drv_rd[0]=1, no ack -> drv_err[0] one-cycle pulse 100 clk after REQ entry, then host_rd=0. Next grant goes to drive 1 if it is requesting.
- Abort and reset: drv_rd[3] dropped in REQ -> host_rd=0 next clk with no err. reset_n low during XFER -> all outputs 0 next clk, grant=0, next request goes to drive 0 first.
- Stray ack: host_ack=1 with host_buff_wr pulses in IDLE -> drv_ack=0, drv_buff_wr=0, busy=0.
